// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: op codes, FSM states and the
// registered response record.
package mem_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_RD  = 2'b01,
    OP_WRW = 2'b10,
    OP_WRB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_EXEC = 2'b10,
    S_RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic [15:0] rdWord;
    logic [7:0]  rdByte;
    logic        err;
  } rsp_t;

  localparam int   WAIT_W   = 4;
  localparam rsp_t RSP_ZERO = '{rdWord: 16'h0000, rdByte: 8'h00, err: 1'b0};

  // Word ops need an even address so that both bytes fall inside the store.
  function automatic logic isWordOp(input op_e op);
    return (op == OP_RD) || (op == OP_WRW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter that paces the wait states; o_done flags the last
// wait cycle (count == 1).
module mem_wait_timer
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_clearN,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_loadVal,
  input  logic              i_dec,
  output logic              o_done
);

  logic [WAIT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clearN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - WAIT_W'(1);
    end
  end

  assign o_done = (r_count == WAIT_W'(1));

endmodule

// File: rtl/data_mem_responder.sv
// Byte-addressed data store answering datapath requests after WAIT wait states,
// with valid/ready handshakes on both the request and response sides.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic        CLOCK,
  input  logic        CLEAR,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [7:0]  req_wbyte,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_word,
  output logic [7:0]  rsp_byte,
  output logic        rsp_err,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_e r_state;
  state_e w_nextState;

  op_e         r_op;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [7:0]  r_wbyte;

  logic [7:0] r_mem [DEPTH];

  rsp_t r_rsp;
  rsp_t w_rsp;

  logic r_reqReady;
  logic r_rspValid;
  logic r_busy;

  logic              w_accept;
  logic              w_timerDone;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_idxHi;
  logic              w_addrHiBad;
  logic              w_reqErr;
  logic              w_memWrLo;
  logic              w_memWrHi;
  logic [7:0]        w_memDataLo;
  logic [7:0]        w_memDataHi;

  assign w_accept = req_valid && (r_state == S_IDLE);

  mem_wait_timer u_timer (
    .i_clk     (CLOCK),
    .i_clearN  (CLEAR),
    .i_load    (w_accept && (WAIT != 0)),
    .i_loadVal (WAIT_W'(WAIT)),
    .i_dec     (r_state == S_WAIT),
    .o_done    (w_timerDone)
  );

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nextState = (WAIT == 0) ? S_EXEC : S_WAIT;
      S_WAIT: if (w_timerDone) w_nextState = S_EXEC;
      S_EXEC: w_nextState = S_RESP;
      S_RESP: if (rsp_ready) w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Handshake/status outputs come from next-state so they are true flops yet
  // still line up with the state they describe.
  always_ff @(posedge CLOCK) begin
    if (!CLEAR) begin
      r_state    <= S_IDLE;
      r_reqReady <= 1'b1;
      r_rspValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_reqReady <= (w_nextState == S_IDLE);
      r_rspValid <= (w_nextState == S_RESP);
      r_busy     <= (w_nextState != S_IDLE);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR) begin
      r_op    <= OP_NOP;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wbyte <= '0;
    end else if (w_accept) begin
      r_op    <= op_e'(req_op);
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wbyte <= req_wbyte;
    end
  end

  assign w_idx       = r_addr[ADDR_W-1:0];
  assign w_idxHi     = w_idx + ADDR_W'(1);
  assign w_addrHiBad = ((r_addr >> ADDR_W) != 16'h0000);
  assign w_reqErr    = (r_op != OP_NOP) && (w_addrHiBad || (isWordOp(r_op) && r_addr[0]));

  // An odd-address read still reports its byte; only the word half is suppressed.
  always_comb begin
    w_rsp       = RSP_ZERO;
    w_rsp.err   = w_reqErr;
    w_memWrLo   = 1'b0;
    w_memWrHi   = 1'b0;
    w_memDataLo = r_wbyte;
    w_memDataHi = r_wdata[15:8];
    case (r_op)
      OP_RD: begin
        if (!w_addrHiBad) w_rsp.rdByte = r_mem[w_idx];
        if (!w_reqErr)    w_rsp.rdWord = {r_mem[w_idxHi], r_mem[w_idx]};
      end
      OP_WRW: begin
        if (!w_reqErr) begin
          w_memWrLo   = 1'b1;
          w_memWrHi   = 1'b1;
          w_memDataLo = r_wdata[7:0];
        end
      end
      OP_WRB: begin
        if (!w_reqErr) w_memWrLo = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR) begin
      r_rsp <= RSP_ZERO;
    end else if (r_state == S_EXEC) begin
      r_rsp <= w_rsp;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!CLEAR) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (r_state == S_EXEC) begin
      if (w_memWrLo) r_mem[w_idx]   <= w_memDataLo;
      if (w_memWrHi) r_mem[w_idxHi] <= w_memDataHi;
    end
  end

  assign req_ready = r_reqReady;
  assign rsp_valid = r_rspValid;
  assign busy      = r_busy;
  assign rsp_word  = r_rsp.rdWord;
  assign rsp_byte  = r_rsp.rdByte;
  assign rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses come from a byte-array
// model when a request is accepted and are matched against handshaken responses.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int WAIT    = 2;
  localparam int TIMEOUT = 60;

  logic        CLOCK = 1'b0;
  logic        CLEAR = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_addr = 16'h0;
  logic [15:0] req_wdata = 16'h0;
  logic [7:0]  req_wbyte = 8'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_word;
  logic [7:0]  rsp_byte;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [15:0] w;
    logic [7:0]  b;
    logic        e;
    int          cyc;
  } rsp_s;

  rsp_s       expQ[$];
  rsp_s       rxQ[$];
  logic [7:0] model [256];

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT)) dut (
    .CLOCK     (CLOCK),
    .CLEAR     (CLEAR),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wbyte (req_wbyte),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_word  (rsp_word),
    .rsp_byte  (rsp_byte),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cycle <= cycle + 1;

  // A response is taken exactly once: at the half-cycle before the edge that completes it.
  always @(negedge CLOCK) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1)
      rxQ.push_back('{w: rsp_word, b: rsp_byte, e: rsp_err, cyc: cycle});
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rsp_s model_access(input logic [1:0] op, input logic [15:0] addr,
                                        input logic [15:0] wd, input logic [7:0] wb);
    rsp_s       r;
    logic [7:0] a;
    logic       hiBad;
    r     = '{w: 16'h0, b: 8'h0, e: 1'b0, cyc: 0};
    a     = addr[7:0];
    hiBad = (addr[15:8] != 8'h00);
    case (op)
      2'b01: begin
        if (hiBad) r.e = 1'b1;
        else begin
          r.b = model[a];
          if (a[0]) r.e = 1'b1;
          else r.w = {model[a + 8'd1], model[a]};
        end
      end
      2'b10: begin
        if (hiBad || a[0]) r.e = 1'b1;
        else begin
          model[a]        = wd[7:0];
          model[a + 8'd1] = wd[15:8];
        end
      end
      2'b11: begin
        if (hiBad) r.e = 1'b1;
        else model[a] = wb;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  task automatic send_req(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [7:0] wb, input bit track, output int acc);
    int n = 0;
    @(negedge CLOCK);
    while (req_ready !== 1'b1 && n < TIMEOUT) begin
      @(negedge CLOCK);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL req_accept: req_ready=%b after %0d cycles, required 1", req_ready, n);
      acc = -1;
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_wbyte = wb;
    @(posedge CLOCK);
    #1;
    acc       = cycle;
    req_valid = 1'b0;
    req_op    = 2'b00;
    if (track) expQ.push_back(model_access(op, addr, wd, wb));
  endtask

  task automatic wait_rsp(output rsp_s r, output bit ok);
    int n = 0;
    while (rxQ.size() == 0 && n < TIMEOUT) begin
      @(negedge CLOCK);
      n++;
    end
    ok = (rxQ.size() != 0);
    if (ok) r = rxQ.pop_front();
    else r = '{w: 16'h0, b: 8'h0, e: 1'b0, cyc: 0};
  endtask

  task automatic test_reset();
    int   acc;
    rsp_s got, ex;
    bit   ok;
    CLEAR     = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1 CLEAR = 1'b1;
    clear_model();
    rxQ.delete();
    expQ.delete();
    @(negedge CLOCK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: ready=%b busy=%b valid=%b, required 1 0 0", req_ready, busy, rsp_valid);
    end
    checks++;
    if (rsp_word !== 16'h0 || rsp_byte !== 8'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: word=%h byte=%h err=%b, required 0000 00 0", rsp_word, rsp_byte, rsp_err);
    end
    send_req(2'b01, 16'h0000, 16'h0, 8'h0, 1'b1, acc);
    send_req(2'b01, 16'h00FE, 16'h0, 8'h0, 1'b1, acc);
    for (int k = 0; k < 2; k++) begin
      wait_rsp(got, ok);
      ex = expQ.pop_front();
      checks++;
      if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
        errors++;
        $display("[TB] FAIL reset_read%0d: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
                 k, got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
      end
    end
  endtask

  task automatic test_word_rw();
    int   accW, accR;
    rsp_s got, ex;
    bit   ok;
    send_req(2'b10, 16'h0010, 16'hBEEF, 8'h0, 1'b1, accW);
    send_req(2'b01, 16'h0010, 16'h0, 8'h0, 1'b1, accR);
    for (int k = 0; k < 2; k++) begin
      wait_rsp(got, ok);
      ex = expQ.pop_front();
      checks++;
      if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
        errors++;
        $display("[TB] FAIL word_rw%0d: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
                 k, got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
      end
    end
    checks++;
    if (got.cyc - accR != WAIT + 1) begin
      errors++;
      $display("[TB] FAIL read_latency: %0d cycles, required %0d", got.cyc - accR, WAIT + 1);
    end
  endtask

  task automatic test_byte_merge();
    int   acc;
    rsp_s got, ex;
    bit   ok;
    send_req(2'b11, 16'h0011, 16'h0, 8'h12, 1'b1, acc);
    send_req(2'b01, 16'h0010, 16'h0, 8'h0, 1'b1, acc);
    send_req(2'b01, 16'h0011, 16'h0, 8'h0, 1'b1, acc);
    send_req(2'b00, 16'h0011, 16'hFFFF, 8'hFF, 1'b1, acc);
    for (int k = 0; k < 4; k++) begin
      wait_rsp(got, ok);
      ex = expQ.pop_front();
      checks++;
      if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
        errors++;
        $display("[TB] FAIL byte_merge%0d: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
                 k, got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
      end
    end
  endtask

  task automatic test_errors();
    int   acc;
    rsp_s got, ex;
    bit   ok;
    send_req(2'b10, 16'h0012, 16'h3456, 8'h0, 1'b1, acc);
    send_req(2'b10, 16'h0013, 16'hAAAA, 8'h0, 1'b1, acc);
    send_req(2'b10, 16'h0100, 16'h5555, 8'h0, 1'b1, acc);
    send_req(2'b11, 16'h0100, 16'h0, 8'h77, 1'b1, acc);
    send_req(2'b01, 16'h0012, 16'h0, 8'h0, 1'b1, acc);
    send_req(2'b01, 16'h0000, 16'h0, 8'h0, 1'b1, acc);
    send_req(2'b01, 16'h00FF, 16'h0, 8'h0, 1'b1, acc);
    for (int k = 0; k < 7; k++) begin
      wait_rsp(got, ok);
      ex = expQ.pop_front();
      checks++;
      if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
        errors++;
        $display("[TB] FAIL errors%0d: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
                 k, got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
      end
    end
  endtask

  task automatic test_backpressure();
    int   acc;
    int   n = 0;
    rsp_s got, ex;
    bit   ok;
    rsp_ready = 1'b0;
    send_req(2'b01, 16'h0010, 16'h0, 8'h0, 1'b1, acc);
    ex = expQ.pop_front();
    while (rsp_valid !== 1'b1 && n < TIMEOUT) begin
      @(negedge CLOCK);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_valid: rsp_valid=%b, required 1", rsp_valid);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_word !== ex.w || rsp_byte !== ex.b || rsp_err !== ex.e) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: valid=%b ready=%b w=%h b=%h e=%b, required 1 0 %h %h %b",
                 k, rsp_valid, req_ready, rsp_word, rsp_byte, rsp_err, ex.w, ex.b, ex.e);
      end
    end
    @(posedge CLOCK);
    #1 rsp_ready = 1'b1;
    @(negedge CLOCK);
    @(negedge CLOCK);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_release: ready=%b busy=%b valid=%b, required 1 0 0", req_ready, busy, rsp_valid);
    end
    wait_rsp(got, ok);
    checks++;
    if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
      errors++;
      $display("[TB] FAIL bp_rsp: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
               got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
    end
  endtask

  task automatic test_back_to_back();
    int   acc [4];
    int   accR;
    rsp_s got, ex;
    bit   ok;
    for (int k = 0; k < 4; k++)
      send_req(2'b11, 16'h0040 + 16'(k), 16'h0, 8'hA0 + 8'(k * 5), 1'b1, acc[k]);
    for (int k = 1; k < 4; k++) begin
      checks++;
      if (acc[k] - acc[k-1] != WAIT + 3) begin
        errors++;
        $display("[TB] FAIL b2b_spacing%0d: %0d cycles between accepts, required %0d", k, acc[k] - acc[k-1], WAIT + 3);
      end
    end
    send_req(2'b01, 16'h0040, 16'h0, 8'h0, 1'b1, accR);
    send_req(2'b01, 16'h0042, 16'h0, 8'h0, 1'b1, accR);
    for (int k = 0; k < 6; k++) begin
      wait_rsp(got, ok);
      ex = expQ.pop_front();
      checks++;
      if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
        errors++;
        $display("[TB] FAIL b2b_rsp%0d: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
                 k, got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    int   acc;
    bit   sawValid = 1'b0;
    rsp_s got, ex;
    bit   ok;
    send_req(2'b10, 16'h0020, 16'h1234, 8'h0, 1'b0, acc);
    @(negedge CLOCK);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_busy: busy=%b before reset, required 1", busy);
    end
    CLEAR = 1'b0;
    @(posedge CLOCK);
    #1 CLEAR = 1'b1;
    clear_model();
    for (int k = 0; k < 8; k++) begin
      @(negedge CLOCK);
      if (rsp_valid !== 1'b0) sawValid = 1'b1;
    end
    checks++;
    if (sawValid || rxQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL midop_norsp: valid seen=%b responses=%0d, required 0 0", sawValid, rxQ.size());
    end
    rxQ.delete();
    send_req(2'b01, 16'h0020, 16'h0, 8'h0, 1'b1, acc);
    send_req(2'b01, 16'h0010, 16'h0, 8'h0, 1'b1, acc);
    for (int k = 0; k < 2; k++) begin
      wait_rsp(got, ok);
      ex = expQ.pop_front();
      checks++;
      if (!ok || got.w !== ex.w || got.b !== ex.b || got.e !== ex.e) begin
        errors++;
        $display("[TB] FAIL midop_read%0d: got w=%h b=%h e=%b seen=%b, required w=%h b=%h e=%b",
                 k, got.w, got.b, got.e, ok, ex.w, ex.b, ex.e);
      end
    end
  endtask

  initial begin
    $display("[TB] start WAIT=%0d ADDR_W=%0d", WAIT, ADDR_W);
    test_reset();
    test_word_rw();
    test_byte_merge();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
